// File: rtl/imm_encoder.sv
// Packs an immediate into an instruction template's immediate fields (inverse of the decode
// sign-extender), range-checks it, and streams results through a 2-entry output FIFO.
module imm_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [2:0]       ImmSrc,
    input  logic [31:0]      ImmIn,
    input  logic [31:0]      Template,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [31:0]      OutInstr,
    output logic             OutErr,
    output logic [CNT_W-1:0] AcceptCount,
    output logic [CNT_W-1:0] ErrCount
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_U = 3'b001,
        FMT_S = 3'b010,
        FMT_B = 3'b011,
        FMT_J = 3'b100
    } fmt_e;

    localparam int ENTRY_W = 33;

    logic [31:0] enc_instr;
    logic        enc_err;
    logic        fits_12;
    logic        fits_20;

    // B and J take halfword offsets, so their ranges match I/S and a 20-bit signed value.
    assign fits_12 = (ImmIn[31:11] == {21{ImmIn[11]}});
    assign fits_20 = (ImmIn[31:19] == {13{ImmIn[19]}});

    always_comb begin
        enc_instr = Template;
        enc_err   = 1'b0;
        case (fmt_e'(ImmSrc))
            FMT_I: begin
                enc_err = !fits_12;
                enc_instr[31:20] = ImmIn[11:0];
            end
            FMT_U: begin
                enc_err = (ImmIn[11:0] != 12'd0);
                enc_instr[31:12] = ImmIn[31:12];
            end
            FMT_S: begin
                enc_err = !fits_12;
                enc_instr[31:25] = ImmIn[11:5];
                enc_instr[11:7]  = ImmIn[4:0];
            end
            FMT_B: begin
                enc_err = !fits_12;
                enc_instr[31]    = ImmIn[11];
                enc_instr[7]     = ImmIn[10];
                enc_instr[30:25] = ImmIn[9:4];
                enc_instr[11:8]  = ImmIn[3:0];
            end
            FMT_J: begin
                enc_err = !fits_20;
                enc_instr[31]    = ImmIn[19];
                enc_instr[19:12] = ImmIn[18:11];
                enc_instr[20]    = ImmIn[10];
                enc_instr[30:21] = ImmIn[9:0];
            end
            default: enc_err = 1'b1;
        endcase
        if (enc_err) begin
            enc_instr = Template;
        end
    end

    logic [ENTRY_W-1:0] mem_q [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;
    logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               push;
    logic               pop;

    assign InReady  = (count_q < 2'd2) && !rst;
    assign OutValid = (count_q != 2'd0);
    assign push     = InValid && InReady;
    assign pop      = OutValid && OutReady;

    assign {OutErr, OutInstr} = mem_q[rd_ptr_q];
    assign AcceptCount        = acc_cnt_q;
    assign ErrCount           = err_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        acc_cnt_d = acc_cnt_q;
        err_cnt_d = err_cnt_q;
        if (push) begin
            wr_ptr_d  = !wr_ptr_q;
            acc_cnt_d = acc_cnt_q + 1'b1;
            if (enc_err && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            acc_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            acc_cnt_q <= acc_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Entries are cleared on reset so the head reads as zero until the first result.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (push && (wr_ptr_q == 1'(gi))) begin
                mem_q[gi] <= {enc_err, enc_instr};
            end
        end
    end

endmodule
